// File: rtl/grey_frame_stats_pkg.sv
// grey_frame_stats_pkg: shared state encoding and default widths for the frame statistics block
package grey_frame_stats_pkg;

    localparam int DEF_W_PIX = 12;
    localparam int DEF_W_CNT = 22;
    localparam int DEF_W_SUM = DEF_W_PIX + DEF_W_CNT;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } statsState_t;

endpackage

// File: rtl/stat_div.sv
// stat_div: restoring unsigned divider, one quotient bit per clock
module stat_div
    import grey_frame_stats_pkg::*;
#(
    parameter int W_SUM = DEF_W_SUM,
    parameter int W_DIV = DEF_W_CNT
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iStart,
    input  logic [W_SUM-1:0] iDividend,
    input  logic [W_DIV-1:0] iDivisor,
    output logic [W_SUM-1:0] oQuotient,
    output logic             oDone
);

    localparam int W_ITER = $clog2(W_SUM + 1);

    logic [W_DIV-1:0]  rem;
    logic [W_DIV:0]    remShift;
    logic [W_DIV-1:0]  divisor;
    logic [W_ITER-1:0] iter;
    logic              fits;

    // Shift the next dividend bit into the partial remainder and test it against the divisor
    always_comb begin
        remShift = {rem, oQuotient[W_SUM-1]};
        fits     = remShift >= {1'b0, divisor};
    end

    // Quotient register doubles as the dividend shifter; iter counts remaining bits
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rem       <= '0;
            oQuotient <= '0;
            divisor   <= '0;
            iter      <= '0;
        end else if (iStart) begin
            rem       <= '0;
            oQuotient <= iDividend;
            divisor   <= iDivisor;
            iter      <= W_ITER'(W_SUM);
        end else if (iter != '0) begin
            rem       <= fits ? W_DIV'(remShift - {1'b0, divisor}) : remShift[W_DIV-1:0];
            oQuotient <= {oQuotient[W_SUM-2:0], fits};
            iter      <= iter - W_ITER'(1);
        end
    end

    // Done is high during the cycle whose closing edge produces the final quotient bit
    always_comb oDone = iter == W_ITER'(1);

endmodule

// File: rtl/grey_frame_stats.sv
// grey_frame_stats: per-frame minimum, maximum and truncated mean of a grey pixel stream
module grey_frame_stats
    import grey_frame_stats_pkg::*;
#(
    parameter int W_PIX = DEF_W_PIX,
    parameter int W_CNT = DEF_W_CNT
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iFrameStart,
    input  logic             iFrameEnd,
    input  logic             iDVAL,
    input  logic [W_PIX-1:0] iGrey,
    output logic [W_PIX-1:0] oMin,
    output logic [W_PIX-1:0] oMax,
    output logic [W_PIX-1:0] oMean,
    output logic             oStatsValid,
    output logic             oBusy
);

    localparam int W_SUM = W_PIX + W_CNT;

    statsState_t      state, stateNext;
    logic [W_SUM-1:0] sum, nextSum;
    logic [W_CNT-1:0] count, nextCount;
    logic [W_PIX-1:0] runMin, runMax, nextMin, nextMax;
    logic [W_SUM-1:0] divQuotient;
    logic             pixTake, divStart, divDone, clearAcc;

    // Accumulator values after the pixel offered this cycle; a saturated counter drops the pixel
    always_comb begin
        pixTake   = iDVAL && (count != '1);
        nextSum   = pixTake ? sum + W_SUM'(iGrey) : sum;
        nextCount = pixTake ? count + W_CNT'(1) : count;
        nextMin   = (pixTake && iGrey < runMin) ? iGrey : runMin;
        nextMax   = (pixTake && iGrey > runMax) ? iGrey : runMax;
        clearAcc  = iFrameStart && (state == IDLE || state == ACCUM);
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNext;
    end

    // Next state; the divider is loaded on the frame-end edge with the sum/count including that pixel
    always_comb begin
        stateNext = state;
        divStart  = 1'b0;
        oBusy     = 1'b0;
        case (state)
            IDLE:   stateNext = iFrameStart ? ACCUM : IDLE;
            ACCUM: begin
                if (!iFrameStart && iFrameEnd) begin
                    stateNext = (nextCount != '0) ? DIVIDE : DONE;
                    divStart  = nextCount != '0;
                end
            end
            DIVIDE: begin
                oBusy     = 1'b1;
                stateNext = divDone ? DONE : DIVIDE;
            end
            DONE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Frame accumulators: cleared on frame start, updated only while accumulating
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sum    <= '0;
            count  <= '0;
            runMin <= '0;
            runMax <= '0;
        end else if (clearAcc) begin
            sum    <= '0;
            count  <= '0;
            runMin <= '1;
            runMax <= '0;
        end else if (state == ACCUM) begin
            sum    <= nextSum;
            count  <= nextCount;
            runMin <= nextMin;
            runMax <= nextMax;
        end
    end

    // Publish results while in DONE; an empty frame reports all zeros.
    // The mean can never exceed the max, so the quotient's upper bits are zero; clamp instead of wrap.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oMin        <= '0;
            oMax        <= '0;
            oMean       <= '0;
            oStatsValid <= 1'b0;
        end else begin
            oStatsValid <= state == DONE;
            if (state == DONE) begin
                oMin  <= (count != '0) ? runMin : '0;
                oMax  <= (count != '0) ? runMax : '0;
                oMean <= (count == '0) ? '0 :
                         (|divQuotient[W_SUM-1:W_PIX]) ? '1 : divQuotient[W_PIX-1:0];
            end
        end
    end

    stat_div #(
        .W_SUM(W_SUM),
        .W_DIV(W_CNT)
    ) uDiv (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iStart   (divStart),
        .iDividend(nextSum),
        .iDivisor (nextCount),
        .oQuotient(divQuotient),
        .oDone    (divDone)
    );

endmodule

// File: tb/tb_grey_frame_stats.sv
// tb_grey_frame_stats: directed frames with hand-computed statistics and latency
module tb_grey_frame_stats;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFrameStart = 1'b0;
    logic        iFrameEnd = 1'b0;
    logic        iDVAL = 1'b0;
    logic [11:0] iGrey = '0;
    logic [11:0] oMin, oMax, oMean;
    logic        oStatsValid, oBusy;

    int nChecks = 0;
    int nErrors = 0;
    int lat;
    int validSeen;
    logic busySeen;

    grey_frame_stats dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iFrameStart(iFrameStart),
        .iFrameEnd  (iFrameEnd),
        .iDVAL      (iDVAL),
        .iGrey      (iGrey),
        .oMin       (oMin),
        .oMax       (oMax),
        .oMean      (oMean),
        .oStatsValid(oStatsValid),
        .oBusy      (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic fe, input logic dv, input logic [11:0] g);
        @(negedge iCLK);
        iFrameStart = fs;
        iFrameEnd   = fe;
        iDVAL       = dv;
        iGrey       = g;
    endtask

    task automatic pixel(input logic [11:0] g);
        drive(1'b0, 1'b0, 1'b1, g);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 12'd0);
    endtask

    // Drive frame end (optionally with a pixel) and count cycles until oStatsValid, bounded
    task automatic endFrame(input logic dv, input logic [11:0] g);
        drive(1'b0, 1'b1, dv, g);
        @(posedge iCLK);
        #1;
        iFrameEnd = 1'b0;
        iDVAL     = 1'b0;
        iGrey     = '0;
        lat       = 1;
        busySeen  = oBusy;
        while (!oStatsValid && lat < 100) begin
            @(posedge iCLK);
            #1;
            lat++;
            busySeen = busySeen | oBusy;
        end
    endtask

    task automatic expectStats(input string tag, input int expLat, input int mn, input int mx, input int mean);
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_min"}, oMin, mn);
        check({tag, "_max"}, oMax, mx);
        check({tag, "_mean"}, oMean, mean);
        @(posedge iCLK);
        #1;
        check({tag, "_pulse"}, oStatsValid, 0);
    endtask

    initial begin
        #12;
        check("rst_min", oMin, 0);
        check("rst_max", oMax, 0);
        check("rst_mean", oMean, 0);
        check("rst_valid", oStatsValid, 0);
        check("rst_busy", oBusy, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        idle(2);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd100);
        pixel(12'd200);
        pixel(12'd300);
        pixel(12'd400);
        endFrame(1'b0, 12'd0);
        expectStats("basic", 36, 100, 400, 250);
        check("basic_busy", busySeen, 1);

        drive(1'b0, 1'b0, 1'b1, 12'd4000);
        drive(1'b0, 1'b1, 1'b1, 12'd4000);
        idle(5);
        check("idle_hold_min", oMin, 100);
        check("idle_hold_max", oMax, 400);
        check("idle_hold_mean", oMean, 250);
        check("idle_no_valid", oStatsValid, 0);
        check("idle_busy", oBusy, 0);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd10);
        pixel(12'd20);
        endFrame(1'b0, 12'd0);
        expectStats("afteridle", 36, 10, 20, 15);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd1);
        pixel(12'd2);
        endFrame(1'b0, 12'd0);
        expectStats("trunc", 36, 1, 2, 1);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        idle(3);
        endFrame(1'b0, 12'd0);
        expectStats("empty", 2, 0, 0, 0);
        check("empty_busy", busySeen, 0);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd3000);
        pixel(12'd5);
        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd50);
        pixel(12'd70);
        endFrame(1'b0, 12'd0);
        expectStats("restart", 36, 50, 70, 60);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd5);
        endFrame(1'b1, 12'd4095);
        expectStats("lastpix", 36, 5, 4095, 2050);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd7);
        drive(1'b0, 1'b1, 1'b0, 12'd0);
        idle(10);
        check("mid_busy", oBusy, 1);
        #2;
        iRST_N = 1'b0;
        #1;
        check("arst_min", oMin, 0);
        check("arst_max", oMax, 0);
        check("arst_mean", oMean, 0);
        check("arst_busy", oBusy, 0);
        check("arst_valid", oStatsValid, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge iCLK);
            #1;
            if (oStatsValid) validSeen++;
        end
        check("arst_no_pulse", validSeen, 0);

        drive(1'b1, 1'b0, 1'b0, 12'd0);
        pixel(12'd100);
        pixel(12'd200);
        pixel(12'd300);
        pixel(12'd400);
        endFrame(1'b0, 12'd0);
        expectStats("postrst", 36, 100, 400, 250);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/grey_frame_stats.md
GREY_FRAME_STATS -- requirements
Module: grey_frame_stats

Interface
REQ-001 SHALL have parameter W_PIX, default 12, pixel width matching the 12-bit grey/RGB channel bus.
REQ-002 SHALL have parameter W_CNT, default 22, pixel-counter width (max 4,194,303 pixels per frame).
REQ-003 SHALL have port iCLK, input, 1, the single pixel clock.
REQ-004 SHALL have port iRST_N, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port iFrameStart, input, 1, one-cycle pulse marking the start of a frame.
REQ-006 SHALL have port iFrameEnd, input, 1, one-cycle pulse marking the end of a frame.
REQ-007 SHALL have port iDVAL, input, 1, pixel-valid qualifier for iGrey.
REQ-008 SHALL have port iGrey, input, W_PIX, grey pixel produced by the eqGrey stage.
REQ-009 SHALL have port oMin, output, W_PIX, minimum grey level of the last measured frame.
REQ-010 SHALL have port oMax, output, W_PIX, maximum grey level of the last measured frame.
REQ-011 SHALL have port oMean, output, W_PIX, truncated mean grey level of the last measured frame.
REQ-012 SHALL have port oStatsValid, output, 1, one-cycle pulse when oMin/oMax/oMean update.
REQ-013 SHALL have port oBusy, output, 1, high while the state is DIVIDE.

Function
REQ-014 SHALL implement the states IDLE, ACCUM, DIVIDE and DONE.
REQ-015 IDLE->ACCUM on iFrameStart; clears sum, count and running max to 0, and running min to all-ones.
REQ-016 ACCUM, iDVAL=1 and count < 2^W_CNT-1: count+1, sum+iGrey (sum width W_PIX+W_CNT), min/max updated; otherwise the pixel is ignored entirely.
REQ-017 ACCUM, iFrameStart: restart accumulation as in REQ-015, discarding the partial frame; iFrameStart beats iFrameEnd in the same cycle.
REQ-018 ACCUM, iFrameEnd: a pixel qualified in that same cycle is included; then ->DIVIDE if count>0, else ->DONE publishing min=max=mean=0.
REQ-019 DIVIDE: restoring divide of sum by count, one quotient bit per cycle, W_PIX+W_CNT iterations, then ->DONE.
REQ-020 DONE (one cycle): register oMin, oMax and oMean (quotient low W_PIX bits, truncated), pulse oStatsValid, ->IDLE.
REQ-021 oStatsValid SHALL rise exactly W_PIX+W_CNT+2 (36 at defaults) clock edges after the edge sampling iFrameEnd when count>0, and 2 edges after when count=0.
REQ-022 iDVAL and iFrameEnd SHALL be ignored in IDLE; iFrameStart, iFrameEnd and iDVAL SHALL be ignored in DIVIDE and DONE (that frame is not measured).
REQ-023 oMin, oMax and oMean SHALL hold their last published values between oStatsValid pulses.

Reset
REQ-024 iRST_N low SHALL force, asynchronously, state IDLE and all outputs, accumulators and divider registers to 0; no oStatsValid pulse is produced for an interrupted frame or divide.

Structure
REQ-025 A shared package SHALL hold the state enum, the W_PIX/W_CNT defaults and the derived sum width W_PIX+W_CNT.
REQ-026 The divider SHALL be a sub-module named stat_div with start/done handshake, dividend, divisor and quotient ports.

Verification
REQ-027 Frame of pixels 100, 200, 300, 400 -> oMin=100, oMax=400, oMean=250, oStatsValid exactly 36 cycles after iFrameEnd.
REQ-028 Frame of pixels 1, 2 -> oMean=1 (truncation), oMin=1, oMax=2.
REQ-029 iFrameStart then iFrameEnd with no iDVAL -> all outputs 0, oStatsValid 2 cycles after iFrameEnd, oBusy never high.
REQ-030 Pixels 4000, 4000, then iFrameStart, then 10, 20, iFrameEnd -> oMin=10, oMax=20, oMean=15; iDVAL pixels in IDLE change nothing.
REQ-031 Last pixel 4095 sampled with iFrameEnd -> included (oMax=4095); iRST_N low mid-DIVIDE -> outputs 0, state IDLE, no oStatsValid.
